// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO, programmable divider and drain interrupt
module uart_tx_periph #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   div, cnt;
  logic [7:0]    shift;
  logic [2:0]    idx;
  logic          ovf, tx_en, irq_en;
  logic          wr, full, empty, busy, bit_end, push, pop, push_ok;
  logic [31:0]   rdata;
  always_comb begin
    wr = en_i & (we_i != 4'd0);
    full = count == CW'(FIFO_DEPTH);
    empty = count == '0;
    busy = state != IDLE;
    bit_end = cnt == 16'd0;
    push = wr & we_i[0] & (addr_i[3:2] == 2'd0);
    pop = ~empty & tx_en & ((state == IDLE) | ((state == STOP) & bit_end));
    push_ok = push & (~full | pop);
    rdata = addr_i[3:2] == 2'd1 ? {16'd0, 8'(count), 4'd0, ovf, busy, empty, full} :
            addr_i[3:2] == 2'd2 ? {16'd0, div} :
            addr_i[3:2] == 2'd3 ? {30'd0, irq_en, tx_en} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      div <= DIV_RESET;
      cnt <= 16'd0;
      shift <= 8'd0;
      idx <= 3'd0;
      ovf <= 1'b0;
      tx_en <= 1'b1;
      irq_en <= 1'b0;
      data_o <= 32'd0;
      tx_o <= 1'b1;
      irq_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push & full & ~pop) ovf <= 1'b1;
      else if (wr & we_i[0] & (addr_i[3:2] == 2'd1) & data_i[3]) ovf <= 1'b0;
      if (wr & we_i[0] & (addr_i[3:2] == 2'd2)) div[7:0] <= data_i[7:0];
      if (wr & we_i[1] & (addr_i[3:2] == 2'd2)) div[15:8] <= data_i[15:8];
      if (wr & we_i[0] & (addr_i[3:2] == 2'd3)) {irq_en, tx_en} <= data_i[1:0];
      if (en_i & ~wr) data_o <= rdata;
      irq_o <= irq_en & empty & ~busy;
      if (pop) begin
        shift <= mem[rd_ptr];
        cnt <= div;
        state <= START;
        tx_o <= 1'b0;
      end else if (busy) begin
        cnt <= bit_end ? div : cnt - 16'd1;
        if (bit_end) begin
          if (state == START) begin
            state <= DATA;
            idx <= 3'd0;
            tx_o <= shift[0];
          end else if ((state == DATA) & (idx != 3'd7)) begin
            idx <= idx + 3'd1;
            shift <= shift >> 1;
            tx_o <= shift[1];
          end else if (state == DATA) begin
            state <= STOP;
            tx_o <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter peripheral for the RS5 system bus, sitting downstream of the core's data-memory port alongside the RTC and PLIC decode slots. It accepts bytes written by software into a TX FIFO and serializes them as 8N1 frames on `tx_o` at a programmable bit period. It replaces simulation-only character output with a synthesizable console path, and raises a level interrupt for the PLIC when the transmitter drains.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd867: reset value of the DIV register; bit period is DIV+1 clk cycles.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en_i`  in  1  bus select for this peripheral; one bus cycle per asserted clk.
- `we_i`  in  4  byte write enables; all zero means read.
- `addr_i`  in  4  register byte offset; bits [1:0] ignored.
- `data_i`  in  32  write data.
- `data_o`  out  32  registered read data.
- `tx_o`  out  1  serial output; idle high.
- `irq_o`  out  1  level interrupt to PLIC source input.

## Operation
Registers:
- 0x0 TXDATA, W: `we_i[0]` pushes `data_i[7:0]`. Read returns 0.
- 0x4 STATUS, R: [0] full, [1] empty, [2] busy (shifter not IDLE), [3] overflow (sticky), [15:8] FIFO count, rest 0. A write with `we_i[0]` and `data_i[3]=1` clears overflow.
- 0x8 DIV, RW [15:0]: `we_i[0]`/`we_i[1]` update the low/high byte. A new value applies from the next bit-counter reload; the bit in progress keeps its length.
- 0xC CTRL, RW: [0] tx_en (reset 1), [1] irq_en (reset 0), written under `we_i[0]`.

FIFO:
- Count width is $clog2(FIFO_DEPTH)+1.
- A push while full is dropped, overflow is set, and the count is unchanged.
- Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Push and pop in the same cycle while not full and not empty: the count is unchanged.
- A pop never happens in the same cycle the FIFO goes from empty to non-empty.

Shifter FSM: IDLE → START → DATA → STOP.
- IDLE: `tx_o`=1. If the FIFO is not empty and tx_en=1, pop the head into the shift register, load bit counter = DIV, go to START.
- START: `tx_o`=0 for DIV+1 cycles, then go to DATA with bit index 0.
- DATA: `tx_o`=shift[0], LSB first, DIV+1 cycles per bit. After bit 7, go to STOP.
- STOP: `tx_o`=1 for DIV+1 cycles. On the last STOP cycle, if the FIFO is not empty and tx_en=1, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Clearing tx_en mid-frame lets the current frame finish; no further pops occur.

Read path:
- When `en_i`=1 and `we_i`=0, `data_o` captures the addressed register at the clock edge.
- In all other cycles `data_o` holds its value.
- Reads of unmapped offsets return 0.
- Reads have no side effects.

Interrupt: `irq_o` is registered as irq_en & empty & ~busy.

## Timing
- Reset values: `tx_o`=1, `data_o`=0, `irq_o`=0, FIFO empty, overflow=0, DIV=`DIV_RESET`, tx_en=1, irq_en=0, FSM=IDLE.
- A reset asserted mid-frame aborts the frame; `tx_o`=1 from the next edge and FIFO contents are discarded.
- Read latency is 1 cycle: the address is sampled at edge E, and `data_o` is valid after E.
- TXDATA write sampled at E0 while IDLE with an empty FIFO: the pop happens at E1, and `tx_o` falls after E1.
- A frame lasts exactly 10·(DIV+1) cycles. Back-to-back frames have no gap.
- STATUS reflects state as of the sampling edge. A push at E0 is visible in count on a read sampled at E1.
- `irq_o` rises 1 cycle after the STOP→IDLE transition when the FIFO is empty.

## Test plan
- Reset, then read DIV, CTRL, and STATUS → 0x363, 0x1, 0x2; `tx_o`=1, `irq_o`=0.
- DIV=3, write 0x55 → `tx_o` falls 1 cycle after the write edge; levels 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (40 cycles total); then `tx_o`=1.
- tx_en=0, write 9 bytes 0x01..0x09 → STATUS count=8, full=1, overflow=1. Set tx_en=1 → exactly bytes 0x01..0x08 are transmitted back-to-back with no idle cycles.
- DIV=1, irq_en=1, write 0xA5 → `irq_o`=0 during the frame and 1 one cycle after STOP ends. Write 0x3C → `irq_o` drops 1 cycle after the push edge.
- Write 0xFF, assert `reset` for 1 cycle during DATA bit 3 → `tx_o`=1 next cycle, STATUS=0x2, and no further frame is sent.
- Write DIV=7 during the DATA bits of a DIV=3 frame → the in-progress bit stays at 4 cycles and the next bit is 8 cycles.
